// File: rtl/demux_pkg.sv
// Shared types and constants for the 4-channel TDM demultiplexer.
package demux_pkg;

  localparam int N_CH  = 4;
  localparam int W_DEF = 4;

  typedef enum logic {IDLE, RECV} state_t;
  typedef logic [1:0] slot_t;

endpackage

// File: rtl/demux_timeout.sv
// Mid-frame idle watchdog; only instantiated when DEMUX_TIMEOUT_EN is defined.
module demux_timeout
  import demux_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic valid_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Fires on the idle cycle that would bring the count to TIMEOUT.
  assign expire_o = run_i && !valid_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || valid_i || expire_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/demux4_tdm.sv
// 4-slot TDM receiver: stages slots 0..2 and publishes A..D atomically on frame end.
// Optional mid-frame idle abort is enabled by defining DEMUX_TIMEOUT_EN.
module demux4_tdm
  import demux_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         valid,
  input  logic         sof,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic [W-1:0] C,
  output logic [W-1:0] D,
  output logic         frame_valid,
  output slot_t        slot,
  output logic         err
);

  state_t       state_q, state_d;
  slot_t        slot_q, slot_d;
  logic [W-1:0] stage_q [N_CH-1];
  logic [W-1:0] stage_d [N_CH-1];
  logic [W-1:0] a_q, b_q, c_q, d_q;
  logic [W-1:0] a_d, b_d, c_d, d_d;
  logic         fv_q, fv_d;
  logic         err_q, err_d;
  logic         timeout_hit;

`ifdef DEMUX_TIMEOUT_EN
  demux_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_i    (state_q == RECV),
    .valid_i  (valid),
    .expire_o (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    stage_d = stage_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid && sof) begin
          stage_d[0] = din;
          slot_d     = 2'd1;
          state_d    = RECV;
        end
      end
      RECV: begin
        // A premature sof restarts the frame in place rather than dropping to IDLE.
        if (valid && sof) begin
          err_d      = 1'b1;
          stage_d[0] = din;
          slot_d     = 2'd1;
        end else if (valid) begin
          if (slot_q == 2'd3) begin
            a_d     = stage_q[0];
            b_d     = stage_q[1];
            c_d     = stage_q[2];
            d_d     = din;
            fv_d    = 1'b1;
            slot_d  = 2'd0;
            state_d = IDLE;
          end else begin
            stage_d[slot_q] = din;
            slot_d          = slot_q + 2'd1;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          slot_d  = 2'd0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      stage_q <= '{default: '0};
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      stage_q <= stage_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign C           = c_q;
  assign D           = d_q;
  assign frame_valid = fv_q;
  assign slot        = slot_q;
  assign err         = err_q;

endmodule

// File: tb/tb_demux4_tdm.sv
// Scoreboard bench for demux4_tdm; timeout scenario runs when DEMUX_TIMEOUT_EN is defined.
module tb_demux4_tdm;

  localparam int W  = 4;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         valid = 1'b0;
  logic         sof = 1'b0;
  logic [W-1:0] A, B, C, D;
  logic         frame_valid, err;
  logic [1:0]   slot;

  demux4_tdm #(.W(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .valid       (valid),
    .sof         (sof),
    .A           (A),
    .B           (B),
    .C           (C),
    .D           (D),
    .frame_valid (frame_valid),
    .slot        (slot),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_err;
    logic [W-1:0] a, b, c, d;
  } ev_t;

  ev_t          exp_q[$];
  logic [W-1:0] part[$];
  bit           in_frame = 1'b0;
`ifdef DEMUX_TIMEOUT_EN
  int           idle = 0;
`endif
  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] cur_a = '0, cur_b = '0, cur_c = '0, cur_d = '0;
  ev_t          mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a frame is a list of words opened by sof; four words make a frame.
  function automatic void model(input bit v, input bit s, input logic [W-1:0] d);
    ev_t e;
`ifdef DEMUX_TIMEOUT_EN
    if (v || !in_frame) idle = 0;
`endif
    if (v && s) begin
      if (in_frame) begin
        e.is_err = 1'b1; e.a = '0; e.b = '0; e.c = '0; e.d = '0;
        exp_q.push_back(e);
      end
      part.delete();
      part.push_back(d);
      in_frame = 1'b1;
    end else if (v && in_frame) begin
      part.push_back(d);
      if (part.size() == 4) begin
        e.is_err = 1'b0;
        e.a = part[0]; e.b = part[1]; e.c = part[2]; e.d = part[3];
        exp_q.push_back(e);
        part.delete();
        in_frame = 1'b0;
      end
`ifdef DEMUX_TIMEOUT_EN
    end else if (!v && in_frame) begin
      idle++;
      if (idle == TO) begin
        e.is_err = 1'b1; e.a = '0; e.b = '0; e.c = '0; e.d = '0;
        exp_q.push_back(e);
        part.delete();
        in_frame = 1'b0;
        idle = 0;
      end
`endif
    end
  endfunction

  function automatic void model_reset();
    part.delete();
    in_frame = 1'b0;
`ifdef DEMUX_TIMEOUT_EN
    idle = 0;
`endif
  endfunction

  function automatic int model_slot();
    return in_frame ? part.size() : 0;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit v, input bit s, input logic [W-1:0] d);
    valid = v;
    sof   = s;
    din   = d;
    model(v, s, d);
    @(posedge clk);
    #1;
    chk("slot", 32'(slot), 32'(model_slot()));
    @(negedge clk);
    valid = 1'b0;
    sof   = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_a = '0; cur_b = '0; cur_c = '0; cur_d = '0;
    end else begin
      if (frame_valid || err) begin
        chk("fv_err_exclusive", 32'(frame_valid && err), 32'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: frame_valid=%0b err=%0b with nothing expected at %0t",
                   frame_valid, err, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk(mon_e.is_err ? "err_pulse" : "frame_pulse", 32'({err, frame_valid}),
              mon_e.is_err ? 32'd2 : 32'd1);
          if (!mon_e.is_err) begin
            cur_a = mon_e.a; cur_b = mon_e.b; cur_c = mon_e.c; cur_d = mon_e.d;
          end
        end
      end
      chk("outputs_ABCD", 32'({A, B, C, D}), 32'({cur_a, cur_b, cur_c, cur_d}));
    end
  end

  initial begin
    bit           rv, rs;
    logic [W-1:0] rd;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ABCD", 32'({A, B, C, D}), 32'd0);
    chk("reset_slot", 32'(slot), 32'd0);
    chk("reset_pulses", 32'({frame_valid, err}), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    repeat (10) step(1'b0, 1'b0, '0);

    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    step(1'b1, 1'b0, 4'h3);
    step(1'b1, 1'b0, 4'h4);

    step(1'b1, 1'b0, 4'h9);
    for (int i = 5; i <= 8; i++) begin
      step(1'b1, (i == 5), W'(i));
      repeat (3) step(1'b0, 1'b0, '0);
    end

    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    step(1'b1, 1'b1, 4'hA);
    step(1'b1, 1'b0, 4'hB);
    step(1'b1, 1'b0, 4'hC);
    step(1'b1, 1'b0, 4'hD);

    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_ABCD", 32'({A, B, C, D}), 32'd0);
    chk("async_reset_slot", 32'(slot), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 1'b0, 4'h3);
    step(1'b1, 1'b0, 4'h4);
    repeat (2) step(1'b0, 1'b0, '0);

`ifdef DEMUX_TIMEOUT_EN
    step(1'b1, 1'b1, 4'h3);
    step(1'b1, 1'b0, 4'h5);
    step(1'b1, 1'b0, 4'h7);
    step(1'b1, 1'b0, 4'h9);
    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    repeat (TO) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 4'h3);
    step(1'b1, 1'b0, 4'h4);
    repeat (2) step(1'b0, 1'b0, '0);
`endif

    repeat (400) begin
      rv = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 4) == 0);
      rd = W'($urandom);
      step(rv, rs, rd);
    end

    repeat (3) step(1'b0, 1'b0, '0);
    @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
